reg_pair_seq16: RTL and testbench
=================================

Name: reg_pair_seq16

Overview:
- Sequences 16-bit register-pair operations (LD rr,nn / INC rr / DEC rr / ADD HL,rr) over the 8-bit register file.
- Sits directly upstream of the register file:
  - drives its reg_selA, reg_selB, load_en, reg_input and flags_in;
  - consumes its reg_outA, reg_outB and flags.
- Each operation takes two register-file write cycles (low byte, then high byte), with the carry held between them.

Parameters:
- None. All widths are fixed by the register file: 8-bit data, 4-bit flags, reg_sel_t selects.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00 LD16, 01 INC16, 10 DEC16, 11 ADD16.
- pair_dst  input  2  00 BC, 01 DE, 10 HL, 11 reserved.
- pair_src  input  2  source pair for ADD16, same encoding; ignored otherwise.
- imm16  input  16  immediate for LD16.
- busy  output  1  high while an operation is in progress (LO, HI, FIN).
- done  output  1  one-cycle completion pulse.
- reg_selA  output  reg_sel_t  register-file write/read select A.
- reg_selB  output  reg_sel_t  register-file read select B.
- load_en  output  1  register-file write enable.
- reg_input  output  8  register-file write data.
- reg_outA  input  8  register-file read data A.
- reg_outB  input  8  register-file read data B.
- flags  input  4  current F: bit3 Z, bit2 N, bit1 H, bit0 C.
- flags_out  output  4  drives register-file flags_in.

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-operation):
  - state goes to IDLE;
  - busy=0, done=0, load_en=0;
  - reg_selA=reg_selB=reg_A, reg_input=0;
  - carry latch cleared; latched command cleared;
  - a partially written pair is left as-is.
- Flags passthrough: the register file loads F every cycle. Therefore flags_out = flags (combinational) in every state and cycle, except the HI cycle of ADD16.
- FSM states: IDLE -> LO -> HI -> FIN -> IDLE, one clock per state.
- IDLE:
  - start=1 latches op, pair_dst, pair_src and imm16, then moves to LO;
  - start=0 stays in IDLE;
  - outputs are at their reset values.
- LO:
  - reg_selA = low byte of dst (C/E/L); reg_selB = low byte of src; load_en=1;
  - reg_input is, per op:
    - LD16: imm16[7:0];
    - INC16: reg_outA+1;
    - DEC16: reg_outA-1;
    - ADD16: reg_outA+reg_outB.
  - carry_q is latched: carry-out for INC/ADD, borrow for DEC, 0 for LD.
- HI:
  - reg_selA = high byte of dst (B/D/H); reg_selB = high byte of src; load_en=1;
  - reg_input is, per op:
    - LD16: imm16[15:8];
    - INC16: reg_outA+carry_q;
    - DEC16: reg_outA-carry_q;
    - ADD16: reg_outA+reg_outB+carry_q.
  - All sums wrap modulo 256 per byte, so 0xFFFF+1 gives 0x0000 and 0x0000-1 gives 0xFFFF.
- ADD16 flags, HI cycle only:
  - flags_out = {flags[3], 0, H, C};
  - H = carry out of bit 11, i.e. reg_outA[3:0]+reg_outB[3:0]+carry_q > 15;
  - C = carry out of bit 15.
  - LD16, INC16 and DEC16 never modify flags.
- FIN: done=1 for exactly this cycle, load_en=0; then IDLE.
- Latency and throughput:
  - start sampled at edge 0;
  - low byte written at edge 1, high byte written at edge 2;
  - done high during cycle 3;
  - next start accepted at edge 4 earliest.
- start while busy: ignored. No queueing, and the latched command is unchanged.
- Reserved pair (11) in pair_dst, or in pair_src for ADD16:
  - the FSM still walks LO/HI/FIN with normal timing and done pulse;
  - load_en stays 0 throughout, flags pass through, no register changes.
- Aliasing: ADD16 with src=dst=HL is legal. L is written at the end of LO; HI reads only H, so the result is HL*2 mod 2^16.
- Command inputs may change freely after the accepting edge.

Test Plan:
- LD16 DE,0x1234 -> load_en=1 in cycles 1 and 2 with reg_selA=reg_E/data 0x34, then reg_selA=reg_D/data 0x12; done in cycle 3; final D=0x12, E=0x34; F unchanged.
- INC16 BC with B=0x00,C=0xFF -> B=0x01, C=0x00. INC16 on HL=0xFFFF -> 0x0000. F unchanged in both.
- DEC16 DE with D=0x10,E=0x00 -> D=0x0F, E=0xFF. DEC16 on 0x0000 -> 0xFFFF. F unchanged.
- ADD16 HL,BC with HL=0x0FFF, BC=0x0001, F=0b1100 -> HL=0x1000, F=0b1010 (Z kept, N=0, H=1, C=0). ADD16 HL,HL with HL=0x8000 -> 0x0000, C=1, H=0.
- Start asserted in cycles 0–5 continuously -> exactly two operations, accepted at edges 0 and 4; done in cycles 3 and 7; busy low only in cycle 4 before re-acceptance.
- rst_n low during HI of INC16 BC (C already written) -> immediate IDLE, load_en=0, busy=0, no done. Reserved pair_dst=11 with start -> no writes, done in cycle 3.

Source files
------------

// File: rtl/reg_pair_seq16.sv
// 16-bit register-pair sequencer: LD rr,nn / INC rr / DEC rr / ADD HL,rr
// executed as two byte-wide register-file writes (low byte, then high byte).
package reg_pair_seq16_pkg;
  typedef enum logic [2:0] {
    reg_A = 3'd0,
    reg_F = 3'd1,
    reg_B = 3'd2,
    reg_C = 3'd3,
    reg_D = 3'd4,
    reg_E = 3'd5,
    reg_H = 3'd6,
    reg_L = 3'd7
  } reg_sel_t;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam logic [1:0] PAIR_BC  = 2'b00;
  localparam logic [1:0] PAIR_DE  = 2'b01;
  localparam logic [1:0] PAIR_HL  = 2'b10;
  localparam logic [1:0] PAIR_RSV = 2'b11;
endpackage

module reg_pair_seq16
  import reg_pair_seq16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [1:0]  pair_dst,
  input  logic [1:0]  pair_src,
  input  logic [15:0] imm16,
  output logic        busy,
  output logic        done,
  output reg_sel_t    reg_selA,
  output reg_sel_t    reg_selB,
  output logic        load_en,
  output logic [7:0]  reg_input,
  input  logic [7:0]  reg_outA,
  input  logic [7:0]  reg_outB,
  input  logic [3:0]  flags,
  output logic [3:0]  flags_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  op_r;
  logic [1:0]  dst_r;
  logic [1:0]  src_r;
  logic [15:0] imm_r;
  logic        ok_r;
  logic        carry_r;

  logic [8:0]  lo_res_s;
  logic [8:0]  hi_res_s;
  logic [4:0]  half_s;

  function automatic reg_sel_t lo_sel(input logic [1:0] p);
    reg_sel_t s;
    case (p)
      PAIR_BC: s = reg_C;
      PAIR_DE: s = reg_E;
      PAIR_HL: s = reg_L;
      default: s = reg_A;
    endcase
    return s;
  endfunction

  function automatic reg_sel_t hi_sel(input logic [1:0] p);
    reg_sel_t s;
    case (p)
      PAIR_BC: s = reg_B;
      PAIR_DE: s = reg_D;
      PAIR_HL: s = reg_H;
      default: s = reg_A;
    endcase
    return s;
  endfunction

  // A reserved pair in any operand the op actually uses suppresses all writes.
  function automatic logic cmd_ok(input logic [1:0] o, input logic [1:0] d,
                                  input logic [1:0] s);
    return (d != PAIR_RSV) && !((o == OP_ADD) && (s == PAIR_RSV));
  endfunction

  // Byte arithmetic; bit 8 of lo_res_s is the carry/borrow handed to HI.
  always_comb begin
    lo_res_s = 9'd0;
    hi_res_s = 9'd0;
    case (op_r)
      OP_LD: begin
        lo_res_s = {1'b0, imm_r[7:0]};
        hi_res_s = {1'b0, imm_r[15:8]};
      end
      OP_INC: begin
        lo_res_s = {1'b0, reg_outA} + 9'd1;
        hi_res_s = {1'b0, reg_outA} + {8'd0, carry_r};
      end
      OP_DEC: begin
        lo_res_s = {1'b0, reg_outA} - 9'd1;
        hi_res_s = {1'b0, reg_outA} - {8'd0, carry_r};
      end
      OP_ADD: begin
        lo_res_s = {1'b0, reg_outA} + {1'b0, reg_outB};
        hi_res_s = {1'b0, reg_outA} + {1'b0, reg_outB} + {8'd0, carry_r};
      end
      default: begin
        lo_res_s = 9'd0;
        hi_res_s = 9'd0;
      end
    endcase
    half_s = {1'b0, reg_outA[3:0]} + {1'b0, reg_outB[3:0]} + {4'd0, carry_r};
  end

  // Write data follows the byte phase; F passes through except on the ADD16 high byte.
  always_comb begin
    reg_input = 8'd0;
    flags_out = flags;
    case (state_r)
      S_LO: begin
        reg_input = lo_res_s[7:0];
        flags_out = flags;
      end
      S_HI: begin
        reg_input = hi_res_s[7:0];
        if (ok_r && (op_r == OP_ADD)) begin
          flags_out = {flags[3], 1'b0, half_s[4], hi_res_s[8]};
        end else begin
          flags_out = flags;
        end
      end
      default: begin
        reg_input = 8'd0;
        flags_out = flags;
      end
    endcase
  end

  // Sequencer FSM with registered handshake and register-file controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      op_r     <= 2'd0;
      dst_r    <= 2'd0;
      src_r    <= 2'd0;
      imm_r    <= 16'd0;
      ok_r     <= 1'b0;
      carry_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_en  <= 1'b0;
      reg_selA <= reg_A;
      reg_selB <= reg_A;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r     <= op;
            dst_r    <= pair_dst;
            src_r    <= pair_src;
            imm_r    <= imm16;
            ok_r     <= cmd_ok(op, pair_dst, pair_src);
            load_en  <= cmd_ok(op, pair_dst, pair_src);
            reg_selA <= lo_sel(pair_dst);
            reg_selB <= lo_sel(pair_src);
            busy     <= 1'b1;
            state_r  <= S_LO;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_LO: begin
          carry_r  <= lo_res_s[8];
          reg_selA <= hi_sel(dst_r);
          reg_selB <= hi_sel(src_r);
          load_en  <= ok_r;
          state_r  <= S_HI;
        end
        S_HI: begin
          reg_selA <= reg_A;
          reg_selB <= reg_A;
          load_en  <= 1'b0;
          done     <= 1'b1;
          state_r  <= S_FIN;
        end
        S_FIN: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          load_en  <= 1'b0;
          reg_selA <= reg_A;
          reg_selB <= reg_A;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_pair_seq16.sv
// Bench for reg_pair_seq16: behavioural register file plus a 16-bit arithmetic
// reference model; directed test-plan steps followed by randomized operations.
module tb_reg_pair_seq16;
  import reg_pair_seq16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  pair_dst;
  logic [1:0]  pair_src;
  logic [15:0] imm16;
  logic        busy;
  logic        done;
  reg_sel_t    reg_selA;
  reg_sel_t    reg_selB;
  logic        load_en;
  logic [7:0]  reg_input;
  logic [7:0]  reg_outA;
  logic [7:0]  reg_outB;
  logic [3:0]  flags;
  logic [3:0]  flags_out;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rf [8];
  logic [3:0] f_reg;
  logic       pset_en = 1'b0;
  logic [2:0] pset_sel = 3'd0;
  logic [7:0] pset_val = 8'd0;
  logic       fset_en = 1'b0;
  logic [3:0] fset_val = 4'd0;

  reg_pair_seq16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .pair_dst(pair_dst), .pair_src(pair_src), .imm16(imm16),
    .busy(busy), .done(done), .reg_selA(reg_selA), .reg_selB(reg_selB),
    .load_en(load_en), .reg_input(reg_input), .reg_outA(reg_outA),
    .reg_outB(reg_outB), .flags(flags), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  // Register file model: two read ports, one write port, F reloaded every cycle.
  assign reg_outA = rf[reg_selA];
  assign reg_outB = rf[reg_selB];
  assign flags    = f_reg;

  always @(posedge clk) begin
    if (pset_en) rf[pset_sel] <= pset_val;
    else if (load_en) rf[reg_selA] <= reg_input;
    if (fset_en) f_reg <= fset_val;
    else f_reg <= flags_out;
  end

  function automatic logic [2:0] lo_i(input logic [1:0] p);
    case (p)
      2'd0: return 3'(reg_C);
      2'd1: return 3'(reg_E);
      2'd2: return 3'(reg_L);
      default: return 3'(reg_A);
    endcase
  endfunction

  function automatic logic [2:0] hi_i(input logic [1:0] p);
    case (p)
      2'd0: return 3'(reg_B);
      2'd1: return 3'(reg_D);
      2'd2: return 3'(reg_H);
      default: return 3'(reg_A);
    endcase
  endfunction

  function automatic logic [15:0] pair_val(input logic [1:0] p);
    return {rf[hi_i(p)], rf[lo_i(p)]};
  endfunction

  function automatic logic [63:0] rf_flat();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = rf[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic poke(input logic [2:0] s, input logic [7:0] v);
    pset_sel = s; pset_val = v; pset_en = 1'b1;
    @(negedge clk);
    pset_en = 1'b0;
  endtask

  task automatic poke_pair(input logic [1:0] p, input logic [15:0] v);
    poke(hi_i(p), v[15:8]);
    poke(lo_i(p), v[7:0]);
  endtask

  task automatic set_f(input logic [3:0] v);
    fset_val = v; fset_en = 1'b1;
    @(negedge clk);
    fset_en = 1'b0;
  endtask

  // One complete operation, called at a negedge while idle; checks every cycle.
  task automatic run_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                        input logic [15:0] im);
    logic        ok;
    logic [15:0] dv, sv, ev;
    logic [16:0] wide;
    logic [12:0] half;
    logic [3:0]  f0, ef;
    logic [63:0] exp_rf;
    ok   = (d != 2'd3) && !((o == 2'd3) && (s == 2'd3));
    dv   = pair_val(d);
    sv   = pair_val(s);
    f0   = f_reg;
    wide = {1'b0, dv} + {1'b0, sv};
    half = {1'b0, dv[11:0]} + {1'b0, sv[11:0]};
    case (o)
      2'd0:    ev = im;
      2'd1:    ev = dv + 16'd1;
      2'd2:    ev = dv - 16'd1;
      default: ev = wide[15:0];
    endcase
    ef = (ok && o == 2'd3) ? {f0[3], 1'b0, half[12], wide[16]} : f0;
    exp_rf = rf_flat();
    if (ok) begin
      exp_rf[int'(lo_i(d))*8 +: 8] = ev[7:0];
      exp_rf[int'(hi_i(d))*8 +: 8] = ev[15:8];
    end
    start = 1'b1; op = o; pair_dst = d; pair_src = s; imm16 = im;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); pair_dst = 2'($urandom);
    pair_src = 2'($urandom); imm16 = 16'($urandom);
    chk("lo_busy", busy, 1'b1);
    chk("lo_done", done, 1'b0);
    chk("lo_load_en", load_en, ok);
    if (ok) chk("lo_selA", reg_selA, lo_i(d));
    if (ok && o == 2'd0) chk("lo_data", reg_input, im[7:0]);
    chk("lo_flags", flags_out, f0);
    @(negedge clk);
    chk("hi_load_en", load_en, ok);
    if (ok) chk("hi_selA", reg_selA, hi_i(d));
    if (ok && o == 2'd0) chk("hi_data", reg_input, im[15:8]);
    chk("hi_flags", flags_out, ef);
    @(negedge clk);
    chk("fin_done", done, 1'b1);
    chk("fin_busy", busy, 1'b1);
    chk("fin_load_en", load_en, 1'b0);
    @(negedge clk);
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("regfile", rf_flat(), exp_rf);
    chk("flags_after", f_reg, ef);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; pair_dst = 2'd0; pair_src = 2'd0; imm16 = 16'd0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_load_en", load_en, 1'b0);
    chk("rst_selA", reg_selA, 3'(reg_A));
    chk("rst_selB", reg_selB, 3'(reg_A));
    chk("rst_data", reg_input, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) poke(3'(i), 8'd0);
    set_f(4'b0101);

    // LD16 DE,0x1234
    run_op(2'd0, 2'd1, 2'd0, 16'h1234);
    chk("ld_de", {rf[3'(reg_D)], rf[3'(reg_E)]}, 16'h1234);
    chk("ld_f", f_reg, 4'b0101);

    // INC16 carry across bytes and full wrap
    poke_pair(2'd0, 16'h00FF);
    run_op(2'd1, 2'd0, 2'd0, 16'h0);
    chk("inc_bc", pair_val(2'd0), 16'h0100);
    poke_pair(2'd2, 16'hFFFF);
    run_op(2'd1, 2'd2, 2'd0, 16'h0);
    chk("inc_hl_wrap", pair_val(2'd2), 16'h0000);

    // DEC16 borrow across bytes and full wrap
    poke_pair(2'd1, 16'h1000);
    run_op(2'd2, 2'd1, 2'd0, 16'h0);
    chk("dec_de", pair_val(2'd1), 16'h0FFF);
    poke_pair(2'd1, 16'h0000);
    run_op(2'd2, 2'd1, 2'd0, 16'h0);
    chk("dec_de_wrap", pair_val(2'd1), 16'hFFFF);
    chk("dec_f", f_reg, 4'b0101);

    // ADD16 HL,BC half-carry, then HL,HL aliasing with carry out
    poke_pair(2'd2, 16'h0FFF);
    poke_pair(2'd0, 16'h0001);
    set_f(4'b1100);
    run_op(2'd3, 2'd2, 2'd0, 16'h0);
    chk("add_hl", pair_val(2'd2), 16'h1000);
    chk("add_f", f_reg, 4'b1010);
    poke_pair(2'd2, 16'h8000);
    run_op(2'd3, 2'd2, 2'd2, 16'h0);
    chk("add_hlhl", pair_val(2'd2), 16'h0000);
    chk("add_hlhl_f", f_reg[1:0], 2'b01);

    // start held for six cycles: two operations, accepted at edges 0 and 4
    poke_pair(2'd0, 16'h00FE);
    start = 1'b1; op = 2'd1; pair_dst = 2'd0; pair_src = 2'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 6) start = 1'b0;
      chk("cont_done", done, (c == 3 || c == 7));
      chk("cont_busy", busy, !(c == 4 || c == 8));
    end
    chk("cont_bc", pair_val(2'd0), 16'h0100);

    // asynchronous reset during HI of INC16 BC leaves C written, B untouched
    poke_pair(2'd0, 16'h12FF);
    start = 1'b1; op = 2'd1; pair_dst = 2'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_load_en", load_en, 1'b0);
    chk("mid_rst_data", reg_input, 8'd0);
    @(negedge clk);
    chk("mid_rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_bc", pair_val(2'd0), 16'h1200);

    // reserved destination and reserved ADD16 source
    run_op(2'd0, 2'd3, 2'd0, 16'hBEEF);
    run_op(2'd3, 2'd2, 2'd3, 16'h0);

    // randomized operations over random register contents
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int p = 0; p < 3; p++) poke_pair(2'(p), 16'($urandom));
        set_f(4'($urandom));
      end
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
